// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the AXI-to-AHB bridge response path.
//   - AXI response code constants
//   - resp_fold / resp_merge: worst-case response accumulation
//   - FSM state encoding for the write-response merge stage
package axi_bridge_pkg;

   localparam int unsigned RESP_W = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESP    = 2'd2
   } bmerge_state_e;

   // EXOKAY carries no meaning for a merged write response, treat as OKAY.
   function automatic logic [RESP_W-1:0] resp_fold(input logic [RESP_W-1:0] r);
      return (r == RESP_EXOKAY) ? RESP_OKAY : r;
   endfunction

   // Accumulate one beat: the numerically largest folded code wins.
   function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] acc,
                                                    input logic [RESP_W-1:0] r);
      logic [RESP_W-1:0] f;
      f = resp_fold(r);
      return (f > acc) ? f : acc;
   endfunction

endpackage

// File: rtl/aw_info_fifo.sv
// Burst-info queue: synchronous FIFO, head readable combinationally.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, din    write (ignored while full)
//   pop, dout    read head / advance (ignored while empty)
//   full         registered, follows the count one cycle after push/pop
//   empty        decoded from the registered count
module aw_info_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q;
   logic             push_ok, pop_ok;

   assign push_ok = push && !full_q;
   assign pop_ok  = pop && (count_q != CNT_W'(0));

   // Occupancy update; simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, count and full flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = (count_q == CNT_W'(0));

endmodule

// File: rtl/axi_bresp_merge.sv
// Write-response merge stage: pops one response per write beat from the
// response FIFO, folds each AW burst into a single worst-case BRESP and
// presents it on the AXI B channel with the burst's ID.
// Optional feature macro: BRESP_ERR_CNT_EN (saturating non-OKAY B counter;
// when undefined err_cnt is tied to zero).
// Ports:
//   clk, resetn                    clock, async active-low reset
//   aw_push, aw_id, aw_len         accepted AW burst info
//   aw_full                        burst-info queue full (registered)
//   resp_empty, resp_data          response FIFO status / head data
//   resp_rd_en                     response FIFO pop (combinational, COLLECT only)
//   bvalid, bready, bid, bresp     AXI B channel
//   err_cnt                        count of non-OKAY B handshakes
module axi_bresp_merge
   import axi_bridge_pkg::*;
#(
   parameter int unsigned ID_W     = 4,
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned AQ_DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             aw_push,
   input  logic [ID_W-1:0]  aw_id,
   input  logic [LEN_W-1:0] aw_len,
   output logic             aw_full,
   input  logic             resp_empty,
   input  logic [1:0]       resp_data,
   output logic             resp_rd_en,
   output logic             bvalid,
   input  logic             bready,
   output logic [ID_W-1:0]  bid,
   output logic [1:0]       bresp,
   output logic [15:0]      err_cnt
);

   localparam int unsigned AQ_W  = ID_W + LEN_W;
   localparam int unsigned CNT_W = 16;

   bmerge_state_e     state_q, state_d;
   logic [ID_W-1:0]   cur_id_q, cur_id_d;
   logic [LEN_W-1:0]  cur_len_q, cur_len_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [RESP_W-1:0] acc_q, acc_d;

   logic              aq_pop, aq_empty;
   logic [AQ_W-1:0]   aq_dout;

   aw_info_fifo #(
      .WIDTH (AQ_W),
      .DEPTH (AQ_DEPTH)
   ) u_aw_info_fifo (
      .clk   (clk),
      .rst_n (resetn),
      .push  (aw_push),
      .pop   (aq_pop),
      .din   ({aw_id, aw_len}),
      .dout  (aq_dout),
      .full  (aw_full),
      .empty (aq_empty)
   );

   // Next-state and response-FIFO pop control.
   always_comb begin
      state_d    = state_q;
      cur_id_d   = cur_id_q;
      cur_len_d  = cur_len_q;
      beat_cnt_d = beat_cnt_q;
      acc_d      = acc_q;
      aq_pop     = 1'b0;
      resp_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (!aq_empty) begin
               aq_pop     = 1'b1;
               cur_id_d   = aq_dout[AQ_W-1 -: ID_W];
               cur_len_d  = aq_dout[LEN_W-1:0];
               beat_cnt_d = '0;
               acc_d      = RESP_OKAY;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            resp_rd_en = !resp_empty;
            if (!resp_empty) begin
               acc_d = resp_merge(acc_q, resp_data);
               // Counter stops at the last beat so len=all-ones never wraps.
               if (beat_cnt_q == cur_len_q) begin
                  state_d = RESP;
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_W'(1);
               end
            end
         end
         RESP: begin
            if (bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and burst context registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         cur_id_q   <= '0;
         cur_len_q  <= '0;
         beat_cnt_q <= '0;
         acc_q      <= RESP_OKAY;
      end else begin
         state_q    <= state_d;
         cur_id_q   <= cur_id_d;
         cur_len_q  <= cur_len_d;
         beat_cnt_q <= beat_cnt_d;
         acc_q      <= acc_d;
      end
   end

   // B channel decoded straight from registers, so it drops with resetn.
   assign bvalid = (state_q == RESP);
   assign bid    = cur_id_q;
   assign bresp  = acc_q;

`ifdef BRESP_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of SLVERR/DECERR handshakes.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bvalid && bready && acc_q[1] && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) err_cnt_q <= '0;
      else         err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule
